// File: rtl/delay_cal_pkg.sv
// Shared definitions for the delay-line tap calibration controller:
// default parameter values and the FSM state encoding.
package delay_cal_pkg;

    localparam int TAP_W_DEF       = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int TIMEOUT_DEF     = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } calState_t;

endpackage

// File: rtl/delay_ret_sync.sv
// Multi-flop synchronizer that brings the asynchronous delay-line return
// into the clk domain; clears to 0 on the synchronous active-low reset.
module delay_ret_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ret,
    output logic retS
);

    logic [SYNC_STAGES-1:0] syncReg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], ret};
        end
    end

    assign retS = syncReg[SYNC_STAGES-1];

endmodule

// File: rtl/delay_tap_cal.sv
// Calibration FSM: fires two-phase events into a tapped delay line, times the
// synchronized return, and steps the tap upward until the delay meets target.
module delay_tap_cal
    import delay_cal_pkg::*;
#(
    parameter int TAP_W       = TAP_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    output logic             launch,
    input  logic             ret,
    output logic [TAP_W-1:0] tap_sel,
    output logic [CNT_W-1:0] meas,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT);
    localparam logic [TAP_W-1:0] TAP_MAX      = '1;

    calState_t        state;
    logic             retS;
    logic             lineIdle;
    logic [CNT_W-1:0] targetReg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] settleCnt;

    delay_ret_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) uRetSync (
        .clk (clk),
        .rst (rst),
        .ret (ret),
        .retS(retS)
    );

    // With two-phase signalling the line is quiet when its output matches the request.
    assign lineIdle = (retS == launch);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            launch    <= 1'b0;
            tap_sel   <= '0;
            meas      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            targetReg <= '0;
            cnt       <= '0;
            settleCnt <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        tap_sel   <= '0;
                        targetReg <= target;
                        busy      <= 1'b1;
                        settleCnt <= '0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    // launch is a registered output, so it flips on entry to LAUNCH
                    if (settleCnt >= SETTLE_LAST && lineIdle) begin
                        launch <= ~launch;
                        state  <= LAUNCH;
                    end else if (settleCnt >= TIMEOUT_LAST) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        settleCnt <= settleCnt + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (lineIdle) begin
                        meas  <= cnt + CNT_W'(1);
                        state <= EVAL;
                    end else if (cnt == TIMEOUT_LAST) begin
                        meas  <= TIMEOUT_VAL;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (meas >= targetReg) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (tap_sel == TAP_MAX) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        tap_sel   <= tap_sel + TAP_W'(1);
                        settleCnt <= '0;
                        state     <= SETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_cal.sv
// Directed bench for delay_tap_cal with a behavioural delay-line model
// (3 cycles per tap, zero delay, or stuck return).
module tb_delay_tap_cal;

    localparam int M_DELAY = 0;
    localparam int M_ZERO  = 1;
    localparam int M_STUCK = 2;

    typedef struct {
        int         mode;
        logic [7:0] tgt;
        bit         expDone;
        bit         expErr;
        int         expTap;
        int         expMeas;
        int         expCycles;
        bit         chkLog;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] target = 8'd0;
    logic       launch;
    logic       ret;
    logic [3:0] tap_sel;
    logic [7:0] meas;
    logic       busy;
    logic       done;
    logic       err;

    int         retMode = M_DELAY;
    logic       stuckVal = 1'b0;
    logic [63:0] launchHist;

    int         nChecks = 0;
    int         nBad = 0;
    int         measLog[$];

    delay_tap_cal dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .launch (launch),
        .ret    (ret),
        .tap_sel(tap_sel),
        .meas   (meas),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Delay line: cleared with the controller's reset, so ret returns to 0.
    always_ff @(posedge clk) begin
        if (!rst) launchHist <= '0;
        else      launchHist <= {launchHist[62:0], launch};
    end

    always_comb begin
        ret = launch;
        case (retMode)
            M_DELAY: ret = (tap_sel == 4'd0) ? launch : launchHist[3 * int'(tap_sel) - 1];
            M_STUCK: ret = stuckVal;
            default: ret = launch;
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic runCal(input logic [7:0] tgt, input int budget, output int cycles);
        logic [7:0] lastMeas;
        bit         timedOut;
        measLog.delete();
        @(posedge clk); #1;
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        check("start_busy", busy, 1);
        check("start_tap", tap_sel, 0);
        check("start_flags", {done, err}, 0);
        lastMeas = meas;
        cycles   = 0;
        timedOut = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (meas != lastMeas) begin
                measLog.push_back(int'(meas));
                lastMeas = meas;
            end
            if (done || err) begin
                cycles   = i;
                timedOut = 1'b0;
                break;
            end
        end
        check("run_timeout", timedOut, 0);
    endtask

    task automatic checkMeasLog(input string name);
        check({name, "_len"}, measLog.size(), 3);
        if (measLog.size() == 3) begin
            check({name, "_m0"}, measLog[0], 2);
            check({name, "_m1"}, measLog[1], 5);
            check({name, "_m2"}, measLog[2], 8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   cycles;
        bit   ok;
        logic launchBefore;

        vecs[0] = '{M_DELAY, 8'd8,  1'b1, 1'b0, 2,  8,   33,  1'b1};
        vecs[1] = '{M_DELAY, 8'd0,  1'b1, 1'b0, 0,  2,   8,   1'b0};
        vecs[2] = '{M_ZERO,  8'd10, 1'b0, 1'b1, 15, 2,   128, 1'b0};
        vecs[3] = '{M_DELAY, 8'd5,  1'b1, 1'b0, 1,  5,   19,  1'b0};
        vecs[4] = '{M_DELAY, 8'd9,  1'b1, 1'b0, 3,  11,  50,  1'b0};
        vecs[5] = '{M_STUCK, 8'd8,  1'b0, 1'b1, 0,  255, 260, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_launch", launch, 0);
        check("rst_tap", tap_sel, 0);
        check("rst_meas", meas, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            retMode  = vecs[i].mode;
            stuckVal = launch;
            runCal(vecs[i].tgt, 600, cycles);
            check($sformatf("v%0d_cycles", i), cycles, vecs[i].expCycles);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_done", i), done, vecs[i].expDone);
            check($sformatf("v%0d_err", i), err, vecs[i].expErr);
            check($sformatf("v%0d_tap", i), tap_sel, vecs[i].expTap);
            check($sformatf("v%0d_meas", i), meas, vecs[i].expMeas);
            check($sformatf("v%0d_busy", i), busy, 0);
            if (vecs[i].chkLog) checkMeasLog($sformatf("v%0d_log", i));
        end

        // Line left busy by the stuck run: no launch may go out, settle times out.
        launchBefore = launch;
        runCal(8'd8, 400, cycles);
        check("hold_cycles", cycles, 255);
        check("hold_err", err, 1);
        check("hold_done", done, 0);
        check("hold_launch", launch, launchBefore);
        check("hold_busy", busy, 0);

        // Mid-run start is ignored, then reset during WAIT of tap 3.
        retMode = M_DELAY;
        @(posedge clk); #1;
        target = 8'd200;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tap_sel == 4'd1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_reach_tap1", ok, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_start_tap", tap_sel, 1);
        check("mid_start_busy", busy, 1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tap_sel == 4'd3) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_reach_tap3", ok, 1);
        launchBefore = launch;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (launch != launchBefore) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_launch_tap3", ok, 1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_wait_busy", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_launch", launch, 0);
        check("mrst_tap", tap_sel, 0);
        check("mrst_meas", meas, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        runCal(8'd8, 600, cycles);
        check("rerun_cycles", cycles, 33);
        check("rerun_done", done, 1);
        check("rerun_err", err, 0);
        check("rerun_tap", tap_sel, 2);
        check("rerun_meas", meas, 8);
        checkMeasLog("rerun_log");

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
